// File: rtl/ps2_frame_receiver_pkg.sv
// Shared types and constants for the PS/2 frame receiver: FSM states,
// frame layout, rejection codes and the odd-parity helper.
package ps2_frame_receiver_pkg;

  // Frame layout: start, 8 data bits LSB-first, odd parity, stop
  localparam int FRAME_W = 11;
  localparam int START_B = 0;
  localparam int PAR_B   = 9;
  localparam int STOP_B  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_FRAMING = 2'b01,
    ERR_PARITY  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

  // Data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Bundle of the PS/2 pins and the frame-output strobes of the receiver.
// master: the side that drives the pins and consumes frames.
// slave : the receiver itself.
interface ps2_frame_receiver_if;

  logic                                       ps2_clk;
  logic                                       ps2_data;
  logic [ps2_frame_receiver_pkg::FRAME_W-1:0] frame;
  logic [7:0]                                 data;
  logic                                       ce;
  logic                                       err;
  logic [1:0]                                 err_code;
  logic                                       busy;

  modport master (
    output ps2_clk, ps2_data,
    input  frame, data, ce, err, err_code, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output frame, data, ce, err, err_code, busy
  );

endinterface

// File: rtl/ps2_frame_receiver_clk_filter.sv
// PS/2 clock conditioning: multi-flop synchroniser, a FILT_LEN-sample
// glitch filter and a registered one-cycle strobe on each filtered fall.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic fall_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample_s;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fall_q, fall_d;

  assign sample_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, idles high like the bus
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  // Level changes only after FILT_LEN consecutive differing samples
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sample_s != level_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        level_d = sample_s;
        cnt_d   = '0;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state and edge strobe registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver. Collects 11-bit frames on filtered
// PS2_CLK falls, validates framing and odd parity in a one-cycle CHECK
// state and emits either a CE strobe with the new frame or an ERR strobe
// with a held cause code. A per-bit idle timer aborts stalled frames.
module ps2_frame_receiver
  import ps2_frame_receiver_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ps2_frame_receiver_if.slave bus
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic                   fall_s;
  logic                   data_s;
  logic [SYNC_STAGES-1:0] dsync_q;

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [FRAME_W-1:0]     shreg_q, shreg_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [7:0]             data_q, data_d;
  logic                   ce_q, ce_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   busy_q, busy_d;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_clk_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (bus.ps2_clk),
    .fall_o (fall_s)
  );

  assign data_s = dsync_q[SYNC_STAGES-1];

  // PS2_DATA synchroniser, idles high like the bus
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dsync_q <= '1;
    end else begin
      dsync_q <= {dsync_q[SYNC_STAGES-2:0], bus.ps2_data};
    end
  end

  // Next-state, shifting, timeout and frame validation
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    shreg_d    = shreg_q;
    frame_d    = frame_q;
    data_d     = data_q;
    ce_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (fall_s && !data_s) begin
          state_d   = ST_SHIFT;
          shreg_d   = '0;
          bit_cnt_d = 4'd1;
        end else begin
          state_d   = ST_IDLE;
          bit_cnt_d = 4'd0;
        end
      end
      ST_SHIFT: begin
        // A fall takes precedence over an expiring timer
        if (fall_s) begin
          shreg_d[bit_cnt_q] = data_s;
          bit_cnt_d          = bit_cnt_q + 4'd1;
          timer_d            = '0;
          if (bit_cnt_q == 4'(STOP_B)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = 4'd0;
          timer_d    = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_CHECK: begin
        // Framing errors outrank parity errors; a fall here is ignored
        state_d   = ST_IDLE;
        bit_cnt_d = 4'd0;
        timer_d   = '0;
        if ((shreg_q[START_B] != 1'b0) || (shreg_q[STOP_B] != 1'b1)) begin
          err_d      = 1'b1;
          err_code_d = ERR_FRAMING;
        end else if (!odd_parity_ok(shreg_q[PAR_B:START_B+1])) begin
          err_d      = 1'b1;
          err_code_d = ERR_PARITY;
        end else begin
          frame_d = shreg_q;
          data_d  = shreg_q[PAR_B-1:START_B+1];
          ce_d    = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 4'd0;
        timer_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      timer_q    <= '0;
      shreg_q    <= '0;
      frame_q    <= '0;
      data_q     <= 8'h00;
      ce_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      shreg_q    <= shreg_d;
      frame_q    <= frame_d;
      data_q     <= data_d;
      ce_q       <= ce_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.frame    = frame_q;
  assign bus.data     = data_q;
  assign bus.ce       = ce_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.busy     = busy_q;

endmodule
